// File: rtl/deserializator.sv
// Serial-to-parallel stage: packs an MSB-first bit stream into WIDTH-bit words with a bit count.
// Optional macro DESER_ALIGN_LSB_EN right-aligns partial words instead of left-aligning them.
module deserializator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_mod_o,
    output logic             deser_data_val_o,
    output logic             busy_o
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    localparam logic [MOD_W:0] CntLast = (MOD_W + 1)'(WIDTH - 1);
    localparam logic [MOD_W:0] CntOne  = (MOD_W + 1)'(1);

    state_e             state_q, state_d;
    logic [MOD_W:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic               val_q, val_d;
    logic [WIDTH-1:0]   bit_mask;
    logic [WIDTH-1:0]   sreg_wr;
    logic [WIDTH-1:0]   partial;

    // Unwritten positions of sreg are always zero, so OR-ing in the new bit is enough.
    assign bit_mask = {ser_data_i, {(WIDTH - 1){1'b0}}} >> cnt_q;
    assign sreg_wr  = sreg_q | bit_mask;

`ifdef DESER_ALIGN_LSB_EN
    logic [MOD_W:0] rshift;
    assign rshift  = (MOD_W + 1)'(WIDTH) - cnt_q;
    assign partial = sreg_q >> rshift;
`else
    assign partial = sreg_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ser_data_val_i) begin
                    sreg_d  = {ser_data_i, {(WIDTH - 1){1'b0}}};
                    cnt_d   = CntOne;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (ser_data_val_i) begin
                    if (cnt_q == CntLast) begin
                        data_d  = sreg_wr;
                        mod_d   = '0;
                        val_d   = 1'b1;
                        cnt_d   = '0;
                        sreg_d  = '0;
                        state_d = StIdle;
                    end else begin
                        sreg_d = sreg_wr;
                        cnt_d  = cnt_q + CntOne;
                    end
                end else begin
                    data_d  = partial;
                    mod_d   = cnt_q[MOD_W-1:0];
                    val_d   = 1'b1;
                    cnt_d   = '0;
                    sreg_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_mod_o      = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = (cnt_q != '0);

endmodule

// File: tb/tb_deserializator.sv
// Self-checking bench for deserializator: scoreboard of expected words checked on each strobe.
// Honours DESER_ALIGN_LSB_EN so the same bench covers both alignment modes.
module tb_deserializator;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        ser_data;
    logic        ser_val;
    logic [15:0] deser_data;
    logic [3:0]  deser_mod;
    logic        deser_val;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cyc[$];

    deserializator #(.WIDTH(16), .MOD_W(4)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_val),
        .deser_data_o     (deser_data),
        .deser_mod_o      (deser_mod),
        .deser_data_val_o (deser_val),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Expected word for n bits taken MSB-first from a left-aligned vector.
    function automatic logic [15:0] model(input logic [15:0] word, input int n);
        logic [15:0] m;
        m = (n >= 16) ? word : (word & ~(16'hFFFF >> n));
`ifdef DESER_ALIGN_LSB_EN
        if (n < 16) m = m >> (16 - n);
`endif
        return m;
    endfunction

    function automatic void push_exp(input logic [15:0] word, input int n);
        exp_t e;
        e.data = model(word, n);
        e.mod  = (n >= 16) ? 4'd0 : 4'(n);
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (arst_n === 1'b1 && deser_val === 1'b1) begin
            strobe_cyc.push_back(cycle);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: data=%h mod=%0d, required no strobe",
                         deser_data, deser_mod);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (deser_data !== e.data) begin
                    fails++;
                    $display("FAIL strobe_data: got %h, required %h", deser_data, e.data);
                end
                tests++;
                if (deser_mod !== e.mod) begin
                    fails++;
                    $display("FAIL strobe_mod: got %0d, required %0d", deser_mod, e.mod);
                end
            end
        end
    end

    task automatic send_bits(input logic [15:0] word, input int n, input bit close);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser_val  = 1'b1;
            ser_data = word[15-i];
            if (i == 15) push_exp(word, 16);
        end
        if (close) begin
            @(negedge clk);
            ser_val  = 1'b0;
            ser_data = 1'($urandom_range(0, 1));
            if (n < 16) push_exp(word, n);
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ser_val  = 1'($urandom_range(0, 1));
            ser_data = 1'($urandom_range(0, 1));
            tests++;
            if ({deser_data, deser_mod, deser_val, busy} !== 22'd0) begin
                fails++;
                $display("FAIL reset_outputs: got data=%h mod=%0d val=%b busy=%b, required all 0",
                         deser_data, deser_mod, deser_val, busy);
            end
        end
        ser_val = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (deser_val !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle: got val=%b busy=%b, required 0 0", deser_val, busy);
            end
        end
    endtask

    task automatic test_partial();
        send_bits(16'hB000, 6, 1'b1);
        drain("partial");
    endtask

    task automatic test_full();
        logic [15:0] w = 16'hB005;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL full_busy_bit%0d: got %b, required 1", k, busy);
                end
            end
            ser_val  = 1'b1;
            ser_data = w[15-k];
        end
        push_exp(w, 16);
        @(negedge clk);
        ser_val = 1'b0;
        tests++;
        if (deser_val !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_latency: got val=%b busy=%b, required val=1 busy=0", deser_val, busy);
        end
        drain("full");
    endtask

    task automatic test_back_to_back();
        strobe_cyc.delete();
        send_bits(16'hA5A5, 16, 1'b0);
        send_bits(16'h0F0F, 16, 1'b1);
        drain("b2b");
        tests++;
        if (strobe_cyc.size() != 2) begin
            fails++;
            $display("FAIL b2b_strobe_count: got %0d, required 2", strobe_cyc.size());
        end else if (strobe_cyc[1] - strobe_cyc[0] != 16) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d cycles, required 16",
                     strobe_cyc[1] - strobe_cyc[0]);
        end
    endtask

    task automatic test_reset_mid_word();
        send_bits(16'hFFFF, 9, 1'b0);
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        tests++;
        if ({deser_data, deser_mod, deser_val, busy} !== 22'd0) begin
            fails++;
            $display("FAIL async_reset: got data=%h mod=%0d val=%b busy=%b, required all 0",
                     deser_data, deser_mod, deser_val, busy);
        end
        ser_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        send_bits(16'hE000, 3, 1'b1);
        drain("reset_mid");
    endtask

    task automatic test_single_bit();
        @(negedge clk);
        ser_val = 1'b0;
        send_bits(16'h8000, 1, 1'b1);
        repeat (10) @(negedge clk);
        drain("single");
    endtask

    initial begin
        ser_val  = 1'b0;
        ser_data = 1'b0;
        arst_n   = 1'b0;
        test_reset();
        test_partial();
        test_full();
        test_back_to_back();
        test_reset_mid_word();
        test_single_bit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
